s27_bist_ctrl: RTL and testbench
================================

# s27_bist_ctrl

Built-in self-test controller for the s27 sequential benchmark core. It starts the core from a known state by holding a fixed flush vector on the primary inputs. It then drives pseudo-random patterns from an 8-bit LFSR onto G0..G3 and compacts output G17 into a 16-bit serial signature register. It sits between the test access logic (START/DONE/PASS) and one s27 instance, and shares the same clock CK.

## Interface
- PATTERNS, 255: number of RUN cycles (1..65535).
- FLUSH_CYC, 2: number of cycles the flush vector is held (1..15).
- FLUSH_VEC, 4'b0111: flush vector {G3,G2,G1,G0}. It forces s27 state G5=1, G6=0, G7=0.
- LFSR_SEED, 8'h01: LFSR load value. Must be nonzero.
- MISR_GOLDEN, 16'h0000: expected signature.
- CK  input  1  clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- START  input  1  begin a test; sampled only in IDLE.
- PO  input  1  s27 output G17. Sampled combinationally in the same cycle as TPAT.
- TPAT  output  4  drives s27 {G3,G2,G1,G0}.
- BUSY  output  1  high in FLUSH and RUN.
- DONE  output  1  sticky; high in state DONE.
- PASS  output  1  valid when DONE=1: SIG==MISR_GOLDEN.
- SIG  output  16  current signature.

## Operation
- States: IDLE, FLUSH, RUN, DONE. The state is encoded in 2 bits.
- IDLE: TPAT=FLUSH_VEC. START=1 loads LFSR_SEED, clears SIG to 0, clears the counter, and moves to FLUSH.
- FLUSH: TPAT=FLUSH_VEC. After FLUSH_CYC edges, moves to RUN. No compaction takes place.
- RUN: TPAT=lfsr[3:0]. On each edge:
  - The LFSR steps: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - The SISR steps: fb=SIG[15]^PO; SIG <= {SIG[14:0],fb} ^ (fb ? 16'h1020 : 16'h0000).
  - After PATTERNS edges, moves to DONE.
- DONE: TPAT=FLUSH_VEC. SIG is frozen. PASS=(SIG==MISR_GOLDEN). START=1 behaves as in IDLE: it restarts directly into FLUSH.
- START is ignored while BUSY.
- The counter is 16-bit. The RUN→DONE transition happens when count==PATTERNS-1 at an edge, so there is no wrap-around.

## Timing
- Reset values: state=IDLE, TPAT=FLUSH_VEC, BUSY=0, DONE=0, PASS=0, SIG=16'h0000, lfsr=LFSR_SEED.
- Reset is asynchronous at any point, including mid-RUN. Outputs go to their reset values immediately. No partial signature is retained.
- With START sampled at edge t0:
  - BUSY=1 from t0.
  - The first RUN pattern appears after edge t0+FLUSH_CYC.
  - DONE=1 and BUSY=0 after edge t0+FLUSH_CYC+PATTERNS. With the defaults this is 257 cycles.
- PASS is registered together with the DONE transition. PASS=0 whenever DONE=0.
- The CUT's combinational path PI→G17 must settle within one CK period. The controller adds no pipeline stages.

## Configuration
- S27_BIST_ABORT_EN defined:
  - Adds port ABORT (input, 1).
  - ABORT=1 in FLUSH or RUN returns the block to IDLE on the next edge, with DONE=0, PASS=0, SIG=0.
  - If ABORT and START are both high in IDLE, ABORT wins and the block stays in IDLE.
  - ABORT is ignored in DONE.
- S27_BIST_ABORT_EN not defined: the ABORT port and its logic are absent.

## Test plan
- Reset value check: pulse RN low mid-RUN (cycle 100) -> TPAT=4'b0111, BUSY=0, DONE=0, SIG=16'h0000 immediately, before the next edge.
- Default-parameter sequencing: START pulse -> BUSY for 257 cycles; TPAT holds 4'b0111 for 2 cycles, then follows 1,2,4,8,1,3.
- PO tied 0, MISR_GOLDEN=16'h0000 -> SIG=16'h0000 and PASS=1 at DONE. With MISR_GOLDEN=16'h0001 -> PASS=0.
- PO tied 1, PATTERNS=1 -> SIG=16'h1021 at DONE. PATTERNS=2 -> SIG=16'h3063.
- s27 instance connected, golden from the C model for seed 8'h01 -> PASS=1. Injecting a stuck-at-0 on G11 -> PASS=0.
- With S27_BIST_ABORT_EN: ABORT at RUN cycle 10 -> IDLE next edge with DONE=0. A following START -> full 257-cycle run and the same signature as an uninterrupted run.

Source files
------------

// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for one s27 core: flush vector, LFSR patterns on G0..G3, SISR over G17 (ABORT port via S27_BIST_ABORT_EN).
// Latency: DONE/PASS rise FLUSH_CYC+PATTERNS edges after START is sampled; PO is compacted in the cycle its pattern is driven.
// Backpressure: none; START is ignored while BUSY, and ABORT (when built in) drops FLUSH/RUN back to IDLE.
module s27_bist_ctrl #(
    parameter int unsigned PATTERNS    = 255,
    parameter int unsigned FLUSH_CYC   = 2,
    parameter logic [3:0]  FLUSH_VEC   = 4'b0111,
    parameter logic [7:0]  LFSR_SEED   = 8'h01,
    parameter logic [15:0] MISR_GOLDEN = 16'h0000
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        START,
    input  logic        PO,
`ifdef S27_BIST_ABORT_EN
    input  logic        ABORT,
`endif
    output logic [3:0]  TPAT,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] SIG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Terminal counts compared against the counter value before the edge, so the counter never wraps.
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [15:0] PAT_LAST   = 16'(PATTERNS - 1);
    localparam logic [15:0] SISR_POLY  = 16'h1020;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic        fb;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            sig_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        fb      = sig_q[15] ^ PO;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_FLUSH;
                    lfsr_d  = LFSR_SEED;
                    sig_d   = 16'h0000;
                    cnt_d   = 16'h0000;
                    pass_d  = 1'b0;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 16'h0000;
                end
            end
            S_RUN: begin
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                sig_d  = {sig_q[14:0], fb} ^ (fb ? SISR_POLY : 16'h0000);
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == PAT_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (sig_d == MISR_GOLDEN);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef S27_BIST_ABORT_EN
        // Abort beats a same-cycle START in IDLE; a finished result in DONE is left untouched.
        if (ABORT && (state_q != S_DONE)) begin
            state_d = S_IDLE;
            lfsr_d  = LFSR_SEED;
            sig_d   = 16'h0000;
            cnt_d   = 16'h0000;
            pass_d  = 1'b0;
        end
`endif
    end

    always_comb begin
        TPAT = FLUSH_VEC;
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            S_FLUSH: BUSY = 1'b1;
            S_RUN: begin
                BUSY = 1'b1;
                TPAT = lfsr_q[3:0];
            end
            S_DONE:  DONE = 1'b1;
            default: ;
        endcase
    end

    assign PASS = pass_q;
    assign SIG  = sig_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: sequencing table, randomized PO against a signature model, s27 good/faulty cores, reset and abort corners.
module tb_s27_bist_ctrl;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, a, e);
        end
    endtask

    logic CK;
    logic RN;
    logic START;
    logic po_r;
    logic seq_end;
`ifdef S27_BIST_ABORT_EN
    logic abort;
`endif

    // s27 netlist evaluation: st={G5,G6,G7}, pi={G3,G2,G1,G0}; returns {G10,G11,G13,G17}.
    function automatic logic [3:0] s27_eval(input logic [2:0] st, input logic [3:0] pi, input bit fault);
        logic g14, g12, g13, g8, g15, g16, g9, g11, g10;
        g14 = ~pi[0];
        g12 = ~(pi[1] | st[0]);
        g13 = ~(pi[2] | g12);
        g8  = g14 & st[1];
        g15 = g12 | g8;
        g16 = pi[3] | g8;
        g9  = ~(g16 & g15);
        g11 = fault ? 1'b0 : ~(st[2] | g9);
        g10 = ~(g14 | g11);
        return {g10, g11, g13, ~g11};
    endfunction

    // Signature register as CRC-style division: shift left, fold in x^12+x^5+1 when the feedback bit is set.
    function automatic logic [15:0] sisr(input logic [15:0] s, input logic b);
        logic f;
        f = s[15] ^ b;
        return (s << 1) ^ (f ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [15:0] cut_sig(input bit fault);
        logic [7:0]  l;
        logic [15:0] s;
        logic [2:0]  st;
        logic [3:0]  r;
        l  = 8'h01;
        s  = 16'h0000;
        st = 3'b100;
        for (int i = 0; i < 255; i++) begin
            r  = s27_eval(st, l[3:0], fault);
            s  = sisr(s, r[0]);
            st = r[3:1];
            l  = {l[6:0], ^(l & 8'hB8)};
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD  = cut_sig(1'b0);
    localparam logic [15:0] FGOLD = cut_sig(1'b1);

    logic [3:0]  tpat_def, tpat_g1, tpat_p1, tpat_p2, tpat_cut, tpat_flt;
    logic        busy_def, busy_g1, busy_p1, busy_p2, busy_cut, busy_flt;
    logic        done_def, done_g1, done_p1, done_p2, done_cut, done_flt;
    logic        pass_def, pass_g1, pass_p1, pass_p2, pass_cut, pass_flt;
    logic [15:0] sig_def, sig_g1, sig_p1, sig_p2, sig_cut, sig_flt;

    logic [2:0]  cut_st = 3'b000;
    logic [2:0]  flt_st = 3'b000;
    logic [3:0]  cut_nx, flt_nx;
    logic        po_cut, po_flt;

    assign cut_nx = s27_eval(cut_st, tpat_cut, 1'b0);
    assign flt_nx = s27_eval(flt_st, tpat_flt, 1'b1);
    assign po_cut = cut_nx[0];
    assign po_flt = flt_nx[0];

    always @(posedge CK) begin
        cut_st <= cut_nx[3:1];
        flt_st <= flt_nx[3:1];
    end

    s27_bist_ctrl u_def (
`ifdef S27_BIST_ABORT_EN
        .ABORT(abort),
`endif
        .CK(CK), .RN(RN), .START(START), .PO(po_r),
        .TPAT(tpat_def), .BUSY(busy_def), .DONE(done_def), .PASS(pass_def), .SIG(sig_def)
    );

    s27_bist_ctrl #(.MISR_GOLDEN(16'h0001)) u_g1 (
`ifdef S27_BIST_ABORT_EN
        .ABORT(abort),
`endif
        .CK(CK), .RN(RN), .START(START), .PO(po_r),
        .TPAT(tpat_g1), .BUSY(busy_g1), .DONE(done_g1), .PASS(pass_g1), .SIG(sig_g1)
    );

    s27_bist_ctrl #(.PATTERNS(1)) u_p1 (
`ifdef S27_BIST_ABORT_EN
        .ABORT(abort),
`endif
        .CK(CK), .RN(RN), .START(START), .PO(1'b1),
        .TPAT(tpat_p1), .BUSY(busy_p1), .DONE(done_p1), .PASS(pass_p1), .SIG(sig_p1)
    );

    s27_bist_ctrl #(.PATTERNS(2)) u_p2 (
`ifdef S27_BIST_ABORT_EN
        .ABORT(abort),
`endif
        .CK(CK), .RN(RN), .START(START), .PO(1'b1),
        .TPAT(tpat_p2), .BUSY(busy_p2), .DONE(done_p2), .PASS(pass_p2), .SIG(sig_p2)
    );

    s27_bist_ctrl #(.MISR_GOLDEN(GOLD)) u_cut (
`ifdef S27_BIST_ABORT_EN
        .ABORT(abort),
`endif
        .CK(CK), .RN(RN), .START(START), .PO(po_cut),
        .TPAT(tpat_cut), .BUSY(busy_cut), .DONE(done_cut), .PASS(pass_cut), .SIG(sig_cut)
    );

    s27_bist_ctrl #(.MISR_GOLDEN(GOLD)) u_flt (
`ifdef S27_BIST_ABORT_EN
        .ABORT(abort),
`endif
        .CK(CK), .RN(RN), .START(START), .PO(po_flt),
        .TPAT(tpat_flt), .BUSY(busy_flt), .DONE(done_flt), .PASS(pass_flt), .SIG(sig_flt)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        seq_end = 1'b0;
        #1000000;
        if (!seq_end) begin
            total++;
            bad++;
            $display("FAIL watchdog: wait for end of sequence expired");
            $finish;
        end
    end

    typedef struct {
        int         k;
        logic [3:0] tpat;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vec[10];

    // mode 0: random PO + table + side instances, 1: PO=0 with a START while busy,
    // 2: reset at cycle 100, 3: abort at RUN cycle 10, 4: plain random run.
    task automatic run_seq(input int mode);
        logic [15:0] sig_m;
        int          ti;
        sig_m = 16'h0000;
        ti    = 0;
        START = 1'b1;
        @(posedge CK);
        #1;
        for (int k = 0; k <= 257; k++) begin
            START = (mode == 1 && k == 50);
            if (mode == 0 && ti < 10 && vec[ti].k == k) begin
                chk("tbl_tpat", tpat_def, vec[ti].tpat);
                chk("tbl_busy", busy_def, vec[ti].busy);
                chk("tbl_done", done_def, vec[ti].done);
                ti++;
            end
            if (mode == 0 && k == 3) begin
                chk("p1_done", done_p1, 1'b1);
                chk("p1_busy", busy_p1, 1'b0);
                chk("p1_tpat", tpat_p1, 4'b0111);
                chk("p1_sig", sig_p1, 16'h1021);
                chk("p1_pass", pass_p1, 1'b0);
            end
            if (mode == 0 && k == 4) begin
                chk("p2_done", done_p2, 1'b1);
                chk("p2_busy", busy_p2, 1'b0);
                chk("p2_tpat", tpat_p2, 4'b0111);
                chk("p2_sig", sig_p2, 16'h3063);
                chk("p2_pass", pass_p2, 1'b0);
            end
            if (k == 100)
                chk("mid_sig", sig_def, sig_m);
            if (mode == 2 && k == 100) begin
                #2 RN = 1'b0;
                #1;
                chk("rst_tpat", tpat_def, 4'b0111);
                chk("rst_busy", busy_def, 1'b0);
                chk("rst_done", done_def, 1'b0);
                chk("rst_pass", pass_def, 1'b0);
                chk("rst_sig", sig_def, 16'h0000);
                #2 RN = 1'b1;
                @(posedge CK);
                #1;
                return;
            end
`ifdef S27_BIST_ABORT_EN
            if (mode == 3 && k == 12) begin
                abort = 1'b1;
                @(posedge CK);
                #1;
                abort = 1'b0;
                chk("abt_busy", busy_def, 1'b0);
                chk("abt_done", done_def, 1'b0);
                chk("abt_pass", pass_def, 1'b0);
                chk("abt_sig", sig_def, 16'h0000);
                chk("abt_tpat", tpat_def, 4'b0111);
                abort = 1'b1;
                START = 1'b1;
                @(posedge CK);
                #1;
                abort = 1'b0;
                START = 1'b0;
                chk("abt_start_busy", busy_def, 1'b0);
                return;
            end
`endif
            if (k == 257) begin
                chk("end_done", done_def, 1'b1);
                chk("end_busy", busy_def, 1'b0);
                chk("end_tpat", tpat_def, 4'b0111);
                chk("end_sig", sig_def, sig_m);
                chk("end_pass", pass_def, (sig_m == 16'h0000));
                chk("g1_sig", sig_g1, sig_m);
                chk("g1_pass", pass_g1, (sig_m == 16'h0001));
                chk("g1_done", done_g1, 1'b1);
                chk("g1_busy", busy_g1, 1'b0);
                chk("g1_tpat", tpat_g1, 4'b0111);
                if (mode == 0) begin
                    chk("cut_sig", sig_cut, GOLD);
                    chk("cut_pass", pass_cut, 1'b1);
                    chk("cut_done", done_cut, 1'b1);
                    chk("cut_busy", busy_cut, 1'b0);
                    chk("flt_sig", sig_flt, FGOLD);
                    chk("flt_pass", pass_flt, (FGOLD == GOLD));
                    chk("flt_done", done_flt, 1'b1);
                    chk("flt_busy", busy_flt, 1'b0);
                end
                break;
            end
            po_r = (mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
            // PO is compacted only while a RUN pattern is on TPAT: cycles 2..256 after START.
            if (k >= 2 && k <= 256)
                sig_m = sisr(sig_m, po_r);
            @(posedge CK);
            #1;
        end
        START = 1'b0;
    endtask

    initial begin
        vec[0] = '{0,   4'b0111, 1'b1, 1'b0};
        vec[1] = '{1,   4'b0111, 1'b1, 1'b0};
        vec[2] = '{2,   4'b0001, 1'b1, 1'b0};
        vec[3] = '{3,   4'b0010, 1'b1, 1'b0};
        vec[4] = '{4,   4'b0100, 1'b1, 1'b0};
        vec[5] = '{5,   4'b1000, 1'b1, 1'b0};
        vec[6] = '{6,   4'b0001, 1'b1, 1'b0};
        vec[7] = '{7,   4'b0011, 1'b1, 1'b0};
        vec[8] = '{256, 4'b0000, 1'b1, 1'b0};
        vec[9] = '{257, 4'b0111, 1'b0, 1'b1};

        RN    = 1'b1;
        START = 1'b0;
        po_r  = 1'b0;
`ifdef S27_BIST_ABORT_EN
        abort = 1'b0;
`endif
        #1 RN = 1'b0;
        #2;
        chk("por_tpat", tpat_def, 4'b0111);
        chk("por_busy", busy_def, 1'b0);
        chk("por_done", done_def, 1'b0);
        chk("por_pass", pass_def, 1'b0);
        chk("por_sig", sig_def, 16'h0000);
        @(negedge CK);
        RN = 1'b1;
        repeat (3) @(posedge CK);
        #1;

        run_seq(0);
        run_seq(1);
        run_seq(2);
        chk("post_rst_busy", busy_def, 1'b0);
`ifdef S27_BIST_ABORT_EN
        run_seq(3);
        run_seq(4);
`endif
        repeat (2) @(posedge CK);
        seq_end = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
